// File: rtl/seg7_mux_display.sv
// Multiplexed common-anode 7-segment driver: sequential double-dabble converter,
// single-clock refresh scan, tear-free digit latch. Option: SEG7_LEADING_ZERO_BLANK_EN.

module seg7_dd_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module seg7_mux_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int IN_WIDTH    = 8,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   number,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg7,
  output logic [NUM_DIGITS-1:0] select
);

  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 1;
    for (int k = 0; k < 10; k++) begin
      if (v >= 10) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int BCD_N = dec_digits(IN_WIDTH);
  localparam int IT_W  = $clog2(IN_WIDTH + 1);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] dig7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [IT_W-1:0]             it_q, it_d;
  logic [IN_WIDTH-1:0]         bin_q, bin_d;
  logic [BCD_N-1:0][3:0]       bcd_q, bcd_d, bcd_adj;
  logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_new;
  logic [BCD_N-1:0]            hi_nz;
  logic                        ovf_q, ovf_new;
  logic                        load, shift_en, latch;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        tick;
  logic [NUM_DIGITS-1:0]       blank;
  logic [NUM_DIGITS-1:0]       sel_q, sel_d;
  logic [6:0]                  seg_q, seg_d;

  // Converter FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_SHIFT;
      S_SHIFT: if (it_q == IT_W'(IN_WIDTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load     = (state_q == S_IDLE);
    shift_en = (state_q == S_SHIFT);
    latch    = (state_q == S_DONE);
    busy     = shift_en;
  end

  // Double-dabble datapath: adjust every nibble, then shift {bcd, bin} left.
  for (genvar i = 0; i < BCD_N; i++) begin : g_nib
    seg7_dd_adj u_adj (.nib_i(bcd_q[i]), .nib_o(bcd_adj[i]));
    if (i < NUM_DIGITS) begin : g_shown
      assign disp_new[i] = bcd_q[i];
      assign hi_nz[i]    = 1'b0;
    end else begin : g_hidden
      assign hi_nz[i] = |bcd_q[i];
    end
  end
  for (genvar i = BCD_N; i < NUM_DIGITS; i++) begin : g_pad
    assign disp_new[i] = 4'd0;
  end
  assign ovf_new = |hi_nz;

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    it_d  = it_q;
    if (load) begin
      bin_d = number;
      bcd_d = '0;
      it_d  = '0;
    end else if (shift_en) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      it_d           = it_q + IT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      it_q  <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      it_q  <= it_d;
    end
  end

  // All digits and overflow move together so the scan never shows a mixed value.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (latch) begin
      disp_q <= disp_new;
      ovf_q  <= ovf_new;
    end
  end

  // Refresh scan
  assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // lz[i]: digit i and every digit above it are zero; the ones digit is never blanked
  logic [NUM_DIGITS-1:0] lz;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    if (i == NUM_DIGITS - 1) begin : g_top
      assign lz[i] = (disp_q[i] == 4'd0);
    end else begin : g_mid
      assign lz[i] = (disp_q[i] == 4'd0) && lz[i+1];
    end
    if (i == 0) begin : g_ones
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign blank[i] = lz[i];
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    sel_d = ~(NUM_DIGITS'(1) << idx_q);
    if (ovf_q)             seg_d = SEG_DASH;
    else if (blank[idx_q]) seg_d = SEG_BLANK;
    else                   seg_d = dig7(disp_q[idx_q]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign select   = sel_q;
  assign seg7     = seg_q;
  assign overflow = ovf_q;

endmodule

// File: doc/seg7_mux_display.md
Name: seg7_mux_display

Overview:
Parametrised multiplexed 7-segment driver for NUM_DIGITS common-anode digits showing an unsigned binary value in decimal. It replaces the fixed 3-digit, divide/modulo, derived-clock display with three pieces. A sequential double-dabble converter, a single-clock refresh tick, and tear-free latching of the converted digits. It sits at the top level between the CPU output register and the board's segment/select pins.

Parameters:
NUM_DIGITS, 4, number of displayed digits (1..8); width of select
IN_WIDTH, 8, width of number input (1..26)
REFRESH_DIV, 50_000, clk cycles each digit stays selected (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
number  input  IN_WIDTH  unsigned value to display
busy  output  1  high while a conversion is in progress
overflow  output  1  latched: displayed value >= 10**NUM_DIGITS
seg7  output  7  segment pattern, active-low, {g,f,e,d,c,b,a}
select  output  NUM_DIGITS  digit enables, active-low one-hot; bit 0 = ones digit

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. No derived or gated clocks. Every register updates on posedge clk only.
- Reset (sampled at posedge clk):
  - select = all 1s; seg7 = 7'b1111111; busy = 0; overflow = 0
  - display digit register = all zeros; digit index = 0; refresh counter = 0; converter FSM = IDLE
- Reset asserted mid-conversion aborts it. The partial result is discarded.
- Converter FSM:
  - IDLE: on every cycle not in reset, capture number into the shift register, clear the BCD field, go to SHIFT, busy=1.
  - SHIFT: IN_WIDTH iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts the combined register left 1. Go to DONE after the last shift.
  - DONE: latch all NUM_DIGITS digits and overflow in one cycle; busy=0; next state IDLE.
  - The converter re-runs continuously. Latency from a number change to updated display is at most 2*(IN_WIDTH+2) cycles.
- Internal BCD width: enough nibbles for 2**IN_WIDTH-1.
  - overflow=1 when any nibble at index >= NUM_DIGITS is non-zero.
  - While overflow=1, every digit shows a dash: seg7 = 7'b0111111.
- number may change during SHIFT. It is ignored until the next IDLE capture. The display never mixes digits from two conversions.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 and wraps. A one-cycle tick fires when count == REFRESH_DIV-1.
  - On tick, digit index increments and wraps NUM_DIGITS-1 -> 0.
  - With NUM_DIGITS=1, the index stays 0.
- Outputs are registered: select/seg7 reflect the index one cycle after it changes.
  - select = ~(1 << index).
  - seg7 = digit_to_7seg(display_digit[index]), or dash on overflow, or blank (7'b1111111) per optional feature.
- Each select value is held exactly REFRESH_DIV cycles, except the first value after reset, which is held REFRESH_DIV cycles counted from the first non-reset edge.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits are blanked (seg7 = 7'b1111111 while selected). Blanked digits are still selected/scanned. The ones digit is never blanked, so value 0 shows "0". Dashes on overflow are not blanked.
- Undefined: all NUM_DIGITS digits are displayed, including leading zeros.

Test Plan:
1. Hold reset 3 cycles with number=8'd42 -> select=4'b1111, seg7=7'b1111111, busy=0, overflow=0 throughout. After release, busy=1 within 1 cycle.
2. NUM_DIGITS=4, REFRESH_DIV=4, number=8'd123, macro off, after 2*(IN_WIDTH+2) cycles:
   - select cycles 1110,1101,1011,0111, then wraps, each held 4 cycles
   - seg7 shows 3,2,1,0 respectively
3. NUM_DIGITS=2, number=8'd255 -> overflow=1; both digits show 7'b0111111. Change to 8'd99 -> overflow=0, shows 9,9.
4. number switches 8'd200 -> 8'd17 while busy=1 -> every sampled select slot shows either {0,0,2,0} or {7,1,0,0}, never a mix.
5. Assert reset for 1 cycle mid-SHIFT with number=8'd88 -> next cycle busy=0, select=all 1s, display register 0. After release, display converges to 8,8.
6. Macro on, number=8'd7, NUM_DIGITS=4 -> digit0=7, digits1..3=7'b1111111. number=0 -> digit0 shows 0, others blank.
